// File: rtl/decoder_buf.sv
// decoder_buf: 2-entry FIFO of 2-bit codes {x,y}, one-hot decoded at the head.
//
// Optional feature: define DEC_COUNT_EN to add the delivered-word counter and
// its `count` port. The default build has neither.
//
// Ports
//   clk        in   sole clock, rising edge
//   rst        in   asynchronous active-high reset
//   x, y       in   code bits (x = MSB), sampled on push
//   in_valid   in   code present
//   in_ready   out  room for a code (EMPTY or ONE)
//   a,b,c,d    out  one-hot decode of head code (11->a, 10->b, 01->c, 00->d)
//   out_valid  out  head word present (ONE or FULL)
//   out_ready  in   consumer takes the head word
//   count      out  words delivered, mod 2^CNT_W (DEC_COUNT_EN only)
module decoder_buf #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             x,
    input  logic             y,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             a,
    output logic             b,
    output logic             c,
    output logic             d,
    output logic             out_valid,
    input  logic             out_ready
`ifdef DEC_COUNT_EN
    ,
    output logic [CNT_W-1:0] count
`endif
);

    localparam int unsigned CODE_W = 2;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    state_e            state_q;
    state_e            state_d;
    logic [CODE_W-1:0] mem_q [2];
    logic              wr_ptr_q;
    logic              rd_ptr_q;
    logic [CODE_W-1:0] head;
    logic              push;
    logic              pop;

    // Handshakes depend only on registered state, so out_ready never reaches in_ready.
    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic on occupancy
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_EMPTY: if (push)         state_d = ST_ONE;
            ST_ONE: begin
                if (push && !pop)       state_d = ST_FULL;
                else if (pop && !push)  state_d = ST_EMPTY;
            end
            ST_FULL:  if (pop)          state_d = ST_ONE;
            default:                    state_d = ST_EMPTY;
        endcase
    end

    // Output decode from state and head entry
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        head      = mem_q[rd_ptr_q];
        {a, b, c, d} = 4'b0000;
        unique case (state_q)
            ST_EMPTY: in_ready = 1'b1;
            ST_ONE: begin
                in_ready  = 1'b1;
                out_valid = 1'b1;
            end
            ST_FULL:  out_valid = 1'b1;
            default: begin
                in_ready  = 1'b0;
                out_valid = 1'b0;
            end
        endcase
        if (out_valid) begin
            unique case (head)
                2'b11:   a = 1'b1;
                2'b10:   b = 1'b1;
                2'b01:   c = 1'b1;
                default: d = 1'b1;
            endcase
        end
    end

    // Storage and pointers; reset discards any buffered codes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= {x, y};
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
        end
    end

`ifdef DEC_COUNT_EN
    logic [CNT_W-1:0] count_q;

    // Delivered-word counter, wraps naturally
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (pop) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign count = count_q;
`endif

endmodule

// File: tb/tb_decoder_buf.sv
module tb_decoder_buf;

    localparam int unsigned CNT_W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic x = 1'b0;
    logic y = 1'b0;
    logic in_valid = 1'b0;
    logic in_ready;
    logic a, b, c, d;
    logic out_valid;
    logic out_ready = 1'b0;
`ifdef DEC_COUNT_EN
    logic [CNT_W-1:0] count;
`endif

    decoder_buf #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .x         (x),
        .y         (y),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c         (c),
        .d         (d),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef DEC_COUNT_EN
        ,
        .count     (count)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: queue of accepted codes plus a delivered-word count.
    logic [1:0]       mq[$];
    logic [CNT_W-1:0] m_cnt = '0;
    int               pops  = 0;
    int               total = 0;
    int               bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [3:0] exp_abcd;
        exp_abcd = (mq.size() > 0) ? (4'b0001 << mq[0]) : 4'b0000;
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(mq.size() > 0));
        chk({tag, ".in_ready"},  32'(in_ready),  32'(mq.size() < 2));
        chk({tag, ".abcd"},      32'({a, b, c, d}), 32'(exp_abcd));
`ifdef DEC_COUNT_EN
        chk({tag, ".count"},     32'(count), 32'(m_cnt));
`endif
    endtask

    // One clock: drive inputs, advance model across the edge, check after it.
    task automatic cycle(input string tag, input logic iv, input logic [1:0] code,
                         input logic ordy);
        logic push;
        logic pop;
        in_valid  = iv;
        {x, y}    = iv ? code : 2'($urandom_range(0, 3));
        out_ready = ordy;
        push = iv && (mq.size() < 2);
        pop  = ordy && (mq.size() > 0);
        @(posedge clk);
        #1;
        if (pop) begin
            void'(mq.pop_front());
            m_cnt = m_cnt + CNT_W'(1);
            pops++;
        end
        if (push) mq.push_back(code);
        check_outputs(tag);
    endtask

    // Assert reset between edges, check the immediate effect, release it.
    task automatic do_reset(input string tag);
        @(negedge clk);
        rst = 1'b1;
        #1;
        mq.delete();
        m_cnt = '0;
        pops  = 0;
        check_outputs(tag);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        do_reset("rst0");

        // Single word 11 with consumer ready
        cycle("single.push", 1'b1, 2'b11, 1'b1);
        chk("single.a", 32'(a), 32'd1);
        cycle("single.pop", 1'b0, 2'b00, 1'b1);

        // Fill under backpressure, third push ignored, then drain in order
        cycle("fill.10", 1'b1, 2'b10, 1'b0);
        cycle("fill.01", 1'b1, 2'b01, 1'b0);
        chk("fill.full_in_ready", 32'(in_ready), 32'd0);
        cycle("fill.ign00", 1'b1, 2'b00, 1'b0);
        cycle("fill.hold", 1'b0, 2'b00, 1'b0);
        chk("fill.head_b", 32'(b), 32'd1);
        cycle("drain.b", 1'b0, 2'b00, 1'b1);
        chk("drain.head_c", 32'(c), 32'd1);
        cycle("drain.c", 1'b0, 2'b00, 1'b1);

        // Simultaneous push and pop while ONE
        cycle("pp.00", 1'b1, 2'b00, 1'b0);
        cycle("pp.11", 1'b1, 2'b11, 1'b1);
        chk("pp.head_a", 32'(a), 32'd1);
        cycle("pp.end", 1'b0, 2'b00, 1'b1);

        // Reset while FULL, then push on first edge after release
        cycle("mid.f0", 1'b1, 2'b01, 1'b0);
        cycle("mid.f1", 1'b1, 2'b10, 1'b0);
        do_reset("mid.rst");
        cycle("mid.first", 1'b1, 2'b00, 1'b0);
        cycle("mid.pop", 1'b0, 2'b00, 1'b1);

        // Counter wrap: exactly 256 pops from reset
        do_reset("wrap.rst");
        while (pops < 256) begin
            cycle("wrap", 1'b1, 2'($urandom_range(0, 3)), 1'b1);
        end
`ifdef DEC_COUNT_EN
        chk("wrap.zero", 32'(count), 32'd0);
`endif

        // Randomized traffic with varying pressure on each side
        for (int ph = 0; ph < 4; ph++) begin
            for (int i = 0; i < 150; i++) begin
                cycle("rand",
                      1'($urandom_range(0, 3) < 3 - ph),
                      2'($urandom_range(0, 3)),
                      1'($urandom_range(0, 3) >= ph));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
